// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: control-unit <-> datapath/memory signal bundle.
// master = control unit (drives strobes, selects, debug state, counter),
// slave  = datapath side (drives Opcode from IR and the memory MemReady).
interface mc_control_unit_if;
    logic [5:0]  Opcode;
    logic        MemReady;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic [1:0]  PCSource;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        RegWrite;
    logic        RegDst;
    logic        IllegalOp;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, IllegalOp, State, InstrCount
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, IllegalOp, State, InstrCount
    );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS sequencer. Steps fetch/decode/execute/
// memory/writeback states, drives datapath selects and write strobes,
// handshakes with the shared memory via MemReady and counts retired
// instructions.
// Optional macro MC_CTRL_ADDI_EN: adds the ADDI path (ADDIEX/ADDIWB);
// without it opcode 6'h08 is reported as illegal.
module mc_control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic               Clk,
    input  logic               Rst,
    mc_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_count;
    logic        retire;

    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic [1:0]  pc_source;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic        reg_dst;
    logic        illegal_op;

    // State register and retired-instruction counter; reset abandons any
    // partially executed instruction.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    // Next-state and Moore output decode (FETCH PC/IR loads follow MemReady).
    always_comb begin
        state_next    = FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        illegal_op    = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = bus.MemReady;
                ir_write  = bus.MemReady;
                state_next = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_next = ADDIEX;
`else
                    OP_ADDI: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (bus.Opcode == OP_LW) begin
                    state_next = MEMRD;
                end else if (bus.Opcode == OP_SW) begin
                    state_next = MEMWR;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = bus.MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.MemReady) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = MEMWR;
                end
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                retire     = 1'b1;
                state_next = FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    // Strobes are suppressed while reset is held; selects stay Moore.
    assign bus.PCWrite     = pc_write      & ~Rst;
    assign bus.PCWriteCond = pc_write_cond & ~Rst;
    assign bus.MemRead     = mem_read      & ~Rst;
    assign bus.MemWrite    = mem_write     & ~Rst;
    assign bus.IRWrite     = ir_write      & ~Rst;
    assign bus.RegWrite    = reg_write     & ~Rst;
    assign bus.IllegalOp   = illegal_op    & ~Rst;
    assign bus.IorD        = i_or_d;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.PCSource    = pc_source;
    assign bus.ALUOp       = alu_op;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.RegDst      = reg_dst;
    assign bus.State       = state;
    assign bus.InstrCount  = instr_count;

endmodule
